valid_move_scanner: RTL
=======================

Name: valid_move_scanner

Overview:
- Sequential successor to the single-cell valid-move evaluator.
- Walks every cell of an m x n Trax board region, row-major, reading the current cell and its four neighbours through a combinational board-read port.
- Applies the team's tile-placement rules to each empty candidate cell and streams each legal move out on a valid/ready interface.
- Reports the total move count, done and overflow. Sits between the board RAM and the move-selection/AI logic.

Parameters:
COORD_W, 10, width of row/column coordinates and of m, n
MAX_MOVES, 203, capacity of the move list downstream; emission stops at this count
K_W, 8, width of move counter k; must hold MAX_MOVES

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a scan; ignored while busy
m  input  COORD_W  row count, latched on start
n  input  COORD_W  column count, latched on start
rd_row  output  COORD_W  row of the cell being examined
rd_col  output  COORD_W  column of the cell being examined
curr_cell  input  3  cell at (rd_row, rd_col), same cycle
up_cell, right_cell, down_cell, left_cell  input  3 each  neighbours of the addressed cell, same cycle
mv_valid  output  1  move word valid
mv_ready  input  1  consumer accepts the word
mv_data  output  2+2*COORD_W  {tile[1:0], col, row}; tile plus=01, slash=10, bslash=11
k  output  K_W  moves emitted so far in this scan
busy  output  1  scan in progress
done  output  1  one-cycle pulse at scan end
overflow  output  1  sticky; MAX_MOVES reached with moves left undelivered

Behaviour:
- Reset (async, any state): state=IDLE, rd_row=rd_col=0, mv_valid=0, mv_data=0, k=0, busy=0, done=0, overflow=0.
- IDLE: on start, latch m and n, clear k and overflow, then go to SCAN at (0,0) with busy=1. If m==0 or n==0, go to DONE instead.
- SCAN (one cycle per cell):
  - Neighbour masking: up forced empty at row 0; down forced empty at row m-1; left forced empty at col 0; right forced empty at col n-1.
  - Candidate requires curr_cell==000. cnt = number of non-empty masked neighbours.
  - Move list, in emission order:
    - cnt 1: plus, slash, bslash.
    - up+right: plus, slash.
    - up+down: bslash, slash.
    - up+left: plus, bslash.
    - right+down: plus, bslash.
    - right+left: bslash, slash.
    - down+left: plus, slash.
    - cnt 0, 3 or 4, or non-empty curr_cell: no moves.
  - Non-empty list: latch the list and go to EMIT; the address holds.
  - Empty list: advance the address in the same cycle.
- EMIT:
  - mv_valid=1 with the current list entry.
  - mv_data is stable while mv_valid && !mv_ready.
  - On each handshake, k increments and the next entry is presented on the following cycle.
  - After the last entry's handshake, advance the address and return to SCAN.
- Address advance and scan end:
  - Advance: col+1; at col==n-1, col=0 and row+1.
  - Advancing from (m-1, n-1) goes to DONE.
- Overflow: if k reaches MAX_MOVES and an undelivered move remains, set overflow=1, drop the remainder, deassert mv_valid and go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE. k and overflow hold until the next start.
- Latency: a cell with no moves costs 1 cycle; a cell with j moves costs at least 1+j cycles.
- start while busy is ignored. m and n changing mid-scan have no effect.

Optional Feature:
- Macro VMOVE_STATS_EN.
- Defined: adds three output ports, cnt_plus, cnt_slash and cnt_bslash, each K_W bits.
  - Each increments on a handshake of its tile type.
  - All three clear on start and on reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- 3x3 board, only (1,1) occupied, mv_ready=1 -> 12 moves, k=12, overflow=0, done pulse.
  - First word with COORD_W=5 is {01, 00001, 00000} (plus, col 1, row 0).
  - Cells (0,1), (1,0), (1,2), (2,1) emitted in row-major order, each as plus, slash, bslash.
- Edge mask: 1x1 board, curr=000, all four neighbour inputs=001 -> no moves, k=0, done after 1 SCAN cycle.
- Backpressure: hold mv_ready=0 for 5 cycles on the first move -> mv_valid=1 and mv_data constant for those cycles, k unchanged until the handshake.
- MAX_MOVES=4 on the 12-move board -> exactly 4 handshakes, k=4, overflow=1, done pulse, mv_valid=0 afterwards.
- m=0 with start -> done pulses within 2 cycles, k=0, mv_valid never asserted.
- Reset asserted mid-EMIT -> outputs go to reset values immediately (async). A new start then reproduces the full 12-move sequence.

Source files
------------

// File: rtl/valid_move_scanner.sv
// valid_move_scanner: walks an m x n Trax board region in row-major order.
// For each empty cell it reads the four neighbours, masks the ones that fall
// outside the region, and streams every legal tile placement on a
// valid/ready interface. It stops emitting at MAX_MOVES and flags overflow.
// Optional build macro VMOVE_STATS_EN adds per-tile handshake counters.
module valid_move_scanner #(
  parameter int COORD_W   = 10,
  parameter int MAX_MOVES = 203,
  parameter int K_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COORD_W-1:0]     m,
  input  logic [COORD_W-1:0]     n,
  output logic [COORD_W-1:0]     rd_row,
  output logic [COORD_W-1:0]     rd_col,
  input  logic [2:0]             curr_cell,
  input  logic [2:0]             up_cell,
  input  logic [2:0]             right_cell,
  input  logic [2:0]             down_cell,
  input  logic [2:0]             left_cell,
  output logic                   mv_valid,
  input  logic                   mv_ready,
  output logic [2+2*COORD_W-1:0] mv_data,
  output logic [K_W-1:0]         k,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
`ifdef VMOVE_STATS_EN
  ,
  output logic [K_W-1:0]         cnt_plus,
  output logic [K_W-1:0]         cnt_slash,
  output logic [K_W-1:0]         cnt_bslash
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  localparam logic [1:0]     T_PLUS   = 2'b01;
  localparam logic [1:0]     T_SLASH  = 2'b10;
  localparam logic [1:0]     T_BSLASH = 2'b11;
  localparam logic [K_W-1:0] K_MAX    = K_W'(MAX_MOVES);

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   row_q, row_d, col_q, col_d;
  logic [COORD_W-1:0]   m_q, m_d, n_q, n_d;
  logic [2:0][1:0]      list_q, list_d;   // entry 0 is emitted first
  logic [1:0]           len_q, len_d, idx_q, idx_d;
  logic [K_W-1:0]       k_q, k_d;
  logic                 ovf_q, ovf_d;

  // masked neighbour occupancy
  logic                 nb_u, nb_r, nb_d, nb_l;
  logic [2:0][1:0]      cand_list;
  logic [1:0]           cand_len;
  // address advance
  logic                 last_col, last_row;
  logic                 hs;

  assign last_col = (col_q == n_q - COORD_W'(1));
  assign last_row = (row_q == m_q - COORD_W'(1));
  assign hs       = (state_q == EMIT) && mv_ready;

  // Neighbours outside the region read as empty whatever the RAM returns.
  always_comb begin
    nb_u = (row_q != '0) && (up_cell    != 3'b000);
    nb_d = !last_row     && (down_cell  != 3'b000);
    nb_l = (col_q != '0) && (left_cell  != 3'b000);
    nb_r = !last_col     && (right_cell != 3'b000);
  end

  // Legal placements for the addressed cell, in emission order.
  always_comb begin
    cand_list = '0;
    cand_len  = 2'd0;
    if (curr_cell == 3'b000) begin
      case ({nb_u, nb_r, nb_d, nb_l})
        4'b1000, 4'b0100, 4'b0010, 4'b0001: begin
          cand_list = {T_BSLASH, T_SLASH, T_PLUS};  cand_len = 2'd3;
        end
        4'b1100: begin cand_list = {2'b00, T_SLASH,  T_PLUS};   cand_len = 2'd2; end
        4'b1010: begin cand_list = {2'b00, T_SLASH,  T_BSLASH}; cand_len = 2'd2; end
        4'b1001: begin cand_list = {2'b00, T_BSLASH, T_PLUS};   cand_len = 2'd2; end
        4'b0110: begin cand_list = {2'b00, T_BSLASH, T_PLUS};   cand_len = 2'd2; end
        4'b0101: begin cand_list = {2'b00, T_SLASH,  T_BSLASH}; cand_len = 2'd2; end
        4'b0011: begin cand_list = {2'b00, T_SLASH,  T_PLUS};   cand_len = 2'd2; end
        default: begin cand_list = '0; cand_len = 2'd0; end
      endcase
    end
  end

  // Next-state: scan sequencing, list latching, move counting, overflow.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    m_d     = m_q;
    n_d     = n_q;
    list_d  = list_q;
    len_d   = len_q;
    idx_d   = idx_q;
    k_d     = k_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        m_d   = m;
        n_d   = n;
        k_d   = '0;
        ovf_d = 1'b0;
        row_d = '0;
        col_d = '0;
        idx_d = 2'd0;
        state_d = (m == '0 || n == '0) ? DONE : SCAN;
      end
      SCAN: begin
        if (cand_len != 2'd0) begin
          if (k_q == K_MAX) begin
            // list already full and this cell still has moves
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            list_d  = cand_list;
            len_d   = cand_len;
            idx_d   = 2'd0;
            state_d = EMIT;
          end
        end else if (last_col && last_row) begin
          state_d = DONE;
        end else if (last_col) begin
          col_d = '0;
          row_d = row_q + COORD_W'(1);
        end else begin
          col_d = col_q + COORD_W'(1);
        end
      end
      EMIT: if (mv_ready) begin
        k_d = k_q + K_W'(1);
        if (idx_q == len_q - 2'd1) begin
          if (last_col && last_row) begin
            state_d = DONE;
          end else begin
            state_d = SCAN;
            if (last_col) begin
              col_d = '0;
              row_d = row_q + COORD_W'(1);
            end else begin
              col_d = col_q + COORD_W'(1);
            end
          end
        end else if (k_q + K_W'(1) == K_MAX) begin
          // remaining entries of this cell are dropped
          ovf_d   = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      m_q     <= '0;
      n_q     <= '0;
      list_q  <= '0;
      len_q   <= 2'd0;
      idx_q   <= 2'd0;
      k_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      m_q     <= m_d;
      n_q     <= n_d;
      list_q  <= list_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rd_row   = row_q;
  assign rd_col   = col_q;
  assign mv_valid = (state_q == EMIT);
  assign mv_data  = mv_valid ? {list_q[idx_q], col_q, row_q} : '0;
  assign k        = k_q;
  assign busy     = (state_q == SCAN) || (state_q == EMIT);
  assign done     = (state_q == DONE);
  assign overflow = ovf_q;

`ifdef VMOVE_STATS_EN
  // Per-tile handshake counters, cleared when a scan is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_plus   <= '0;
      cnt_slash  <= '0;
      cnt_bslash <= '0;
    end else if (state_q == IDLE && start) begin
      cnt_plus   <= '0;
      cnt_slash  <= '0;
      cnt_bslash <= '0;
    end else if (hs) begin
      case (list_q[idx_q])
        T_PLUS:   cnt_plus   <= cnt_plus   + K_W'(1);
        T_SLASH:  cnt_slash  <= cnt_slash  + K_W'(1);
        T_BSLASH: cnt_bslash <= cnt_bslash + K_W'(1);
        default:  ;
      endcase
    end
  end
`endif

endmodule
